// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the Tomasulo common data bus: picks one functional
// unit per cycle and registers {valid, payload} onto the CDB.
module cdb_arbiter #(
    parameter int NUM_REQ   = 5,
    parameter int PAYLOAD_W = 38,
    parameter int CNT_W     = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_payload,
    input  logic                           hold,
    output logic [PAYLOAD_W:0]             cdb,
    output logic [NUM_REQ-1:0]             grant,
    output logic [CNT_W-1:0]               bcast_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PAYLOAD_W:0]   cdb_reg;
    logic [NUM_REQ-1:0]   grant_reg;
    logic [PTR_W-1:0]     ptr_reg;
    logic [CNT_W-1:0]     count_reg;

    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   win_onehot;
    logic [PTR_W-1:0]     win_idx;
    logic                 win_found;
    logic [PTR_W-1:0]     ptr_next;
    logic [PAYLOAD_W-1:0] payload_sel;
    logic [PAYLOAD_W-1:0] masked [NUM_REQ];

    // The unit currently on the bus sits out one edge so it is not sent twice.
    assign eligible = req & ~grant_reg;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_found  = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            logic [PTR_W:0]   sum;
            logic [PTR_W-1:0] idx;
            sum = {1'b0, ptr_reg} + (PTR_W+1)'(off);
            if (sum >= (PTR_W+1)'(NUM_REQ))
                sum = sum - (PTR_W+1)'(NUM_REQ);
            idx = sum[PTR_W-1:0];
            if (!win_found && eligible[idx]) begin
                win_found       = 1'b1;
                win_idx         = idx;
                win_onehot[idx] = 1'b1;
            end
        end
    end

    assign ptr_next = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);

    // AND-OR mux: non-winning slots are forced to zero so junk never leaks.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign masked[gi] = req_payload[gi*PAYLOAD_W +: PAYLOAD_W]
                              & {PAYLOAD_W{win_onehot[gi]}};
        end
    endgenerate

    always_comb begin
        payload_sel = '0;
        for (int i = 0; i < NUM_REQ; i++)
            payload_sel = payload_sel | masked[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_reg   <= '0;
            grant_reg <= '0;
            ptr_reg   <= '0;
            count_reg <= '0;
        end else if (win_found && !hold) begin
            cdb_reg   <= {1'b1, payload_sel};
            grant_reg <= win_onehot;
            ptr_reg   <= ptr_next;
            if (count_reg != {CNT_W{1'b1}})
                count_reg <= count_reg + CNT_W'(1);
        end else begin
            cdb_reg   <= '0;
            grant_reg <= '0;
        end
    end

    assign cdb         = cdb_reg;
    assign grant       = grant_reg;
    assign bcast_count = count_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_cdb_arbiter;

    localparam int N  = 5;
    localparam int PW = 38;
    localparam int CW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req = '0;
    logic [N*PW-1:0]   req_payload = '0;
    logic              hold = 1'b0;
    logic [PW:0]       cdb;
    logic [N-1:0]      grant;
    logic [CW-1:0]     bcast_count;

    // Single-requester, 4-bit-counter build: blackout and saturation.
    logic              s_rst = 1'b1;
    logic [0:0]        s_req = 1'b1;
    logic [PW-1:0]     s_payload = 38'h15_12345678;
    logic              s_hold = 1'b0;
    logic [PW:0]       s_cdb;
    logic [0:0]        s_grant;
    logic [3:0]        s_count;

    int n_checks = 0;
    int n_errors = 0;
    bit run_cmp  = 1'b0;

    cdb_arbiter #(.NUM_REQ(N), .PAYLOAD_W(PW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_payload(req_payload), .hold(hold),
        .cdb(cdb), .grant(grant), .bcast_count(bcast_count)
    );

    cdb_arbiter #(.NUM_REQ(1), .PAYLOAD_W(PW), .CNT_W(4)) dut_s (
        .clk(clk), .rst(s_rst), .req(s_req), .req_payload(s_payload), .hold(s_hold),
        .cdb(s_cdb), .grant(s_grant), .bcast_count(s_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: remember who is on the bus, scan from the pointer.
    int          m_ptr   = 0;
    int          m_last  = -1;
    logic [CW-1:0] m_count = '0;
    logic [PW:0]   m_cdb   = '0;

    always @(posedge clk or posedge rst) begin : model
        int w;
        int c;
        if (rst) begin
            m_ptr = 0; m_last = -1; m_count = '0; m_cdb = '0;
        end else begin
            w = -1;
            if (!hold) begin
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (w < 0 && req[c] && c != m_last) w = c;
                end
            end
            if (w >= 0) begin
                m_cdb  = {1'b1, req_payload[w*PW +: PW]};
                m_last = w;
                m_ptr  = (w + 1) % N;
                if (m_count != {CW{1'b1}}) m_count = m_count + 1;
            end else begin
                m_cdb  = '0;
                m_last = -1;
            end
        end
    end

    bit          sm_on    = 1'b0;
    logic [3:0]  sm_count = '0;
    logic [PW:0] sm_cdb   = '0;

    always @(posedge clk or posedge s_rst) begin : s_model
        if (s_rst) begin
            sm_on = 1'b0; sm_count = '0; sm_cdb = '0;
        end else if (s_req[0] && !sm_on && !s_hold) begin
            sm_on  = 1'b1;
            sm_cdb = {1'b1, s_payload};
            if (sm_count != 4'hF) sm_count = sm_count + 4'd1;
        end else begin
            sm_on  = 1'b0;
            sm_cdb = '0;
        end
    end

    always @(negedge clk) begin : compare
        logic [N-1:0] eg;
        if (run_cmp && !rst) begin
            eg = '0;
            if (m_last >= 0) eg[m_last] = 1'b1;
            check("cdb", 64'(cdb), 64'(m_cdb));
            check("grant", 64'(grant), 64'(eg));
            check("bcast_count", 64'(bcast_count), 64'(m_count));
        end
        if (run_cmp && !s_rst) begin
            check("s_cdb", 64'(s_cdb), 64'(sm_cdb));
            check("s_grant", 64'(s_grant), 64'(sm_on));
            check("s_count", 64'(s_count), 64'(sm_count));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    task automatic junk_payloads();
        for (int i = 0; i < N; i++)
            req_payload[i*PW +: PW] = PW'({$urandom(), $urandom()});
    endtask

    initial begin
        logic [PW:0]   exp_bcast;
        logic [PW-1:0] p0;
        logic [N-1:0]  eg;
        logic          v_prev;

        exp_bcast = 39'h4A_DEADBEEF;
        p0        = 38'h0A_DEADBEEF;

        #12 rst = 1'b0; s_rst = 1'b0; run_cmp = 1'b1;

        // Single requester: broadcast, blackout, rebroadcast.
        junk_payloads();
        req = 5'b00001;
        req_payload[0 +: PW] = p0;
        step();
        check("t1_cdb_e1", 64'(cdb), 64'(exp_bcast));
        check("t1_grant_e1", 64'(grant), 64'h1);
        step();
        check("t1_cdb_blackout", 64'(cdb), 64'h0);
        check("t1_grant_blackout", 64'(grant), 64'h0);
        step();
        check("t1_cdb_e3", 64'(cdb), 64'(exp_bcast));
        check("t1_count_e3", 64'(bcast_count), 64'd2);

        // All requesting: rotation with wrap 4 -> 0.
        pulse_reset();
        req = 5'b11111;
        for (int k = 0; k < 10; k++) begin
            step();
            eg = '0;
            eg[k % N] = 1'b1;
            check("t2_rotate", 64'(grant), 64'(eg));
        end
        check("t2_count", 64'(bcast_count), 64'd10);

        // Wrap scan from ptr=2: index 4 beats index 0.
        pulse_reset();
        req = 5'b00010;
        step();
        req = 5'b10001;
        step();
        check("t3_g1", 64'(grant), 64'h10);
        step();
        check("t3_g2", 64'(grant), 64'h01);
        step();
        check("t3_g3", 64'(grant), 64'h10);

        // Hold freezes grant, pointer and count.
        pulse_reset();
        req = 5'b00001;
        step();
        hold = 1'b1;
        req  = 5'b00110;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t4_hold_cdb", 64'(cdb), 64'h0);
            check("t4_hold_grant", 64'(grant), 64'h0);
            check("t4_hold_count", 64'(bcast_count), 64'd1);
        end
        hold = 1'b0;
        step();
        check("t4_resume_grant", 64'(grant), 64'h02);
        check("t4_resume_count", 64'(bcast_count), 64'd2);

        // Asynchronous reset drops the bus before the next edge.
        check("t5_pre_valid", 64'(cdb[PW]), 64'h1);
        #1 rst = 1'b1;
        #1;
        check("t5_async_cdb", 64'(cdb), 64'h0);
        check("t5_async_grant", 64'(grant), 64'h0);
        check("t5_async_count", 64'(bcast_count), 64'h0);
        rst = 1'b0;
        req = 5'b01100;
        step();
        check("t5_first_grant", 64'(grant), 64'h04);

        // Randomized traffic with junk on idle payload slots.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            case ($urandom_range(0, 3))
                0:       req = N'($urandom());
                1:       req = N'($urandom() & $urandom());
                2:       req = '1;
                default: req = N'(1) << $urandom_range(0, N - 1);
            endcase
            hold = ($urandom_range(0, 9) == 0);
            junk_payloads();
            s_payload = PW'({$urandom(), $urandom()});
            if (cyc % 700 == 699) pulse_reset();
            step();
        end

        // Single-requester build: alternate grants, saturated counter.
        hold = 1'b0;
        v_prev = s_cdb[PW];
        step();
        check("s_alternate", 64'(s_cdb[PW]), 64'(!v_prev));
        check("s_saturated", 64'(s_count), 64'hF);
        step();
        check("s_saturated_hold", 64'(s_count), 64'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among the functional units of the Tomasulo core: load/store, add, mul, div and jump.
- Each unit raises a level request together with its CDB payload; the payload is {FU tag, RS one-hot, 32-bit result}.
- The arbiter picks one winner per cycle with round-robin priority and registers {valid, payload} onto the CDB.
- It masks the previous winner for one cycle, so a unit whose request is still high while it observes its own broadcast is not sent twice.

Parameters:
- NUM_REQ, 5, number of requesting functional units; index 0 = load/store, 1 = add, 2 = mul, 3 = div, 4 = jump.
- PAYLOAD_W, 38, per-unit payload width: 3-bit FU tag + 3-bit RS one-hot + 32-bit data. Equals NUM_CDBBITS-1.
- CNT_W, 32, width of the broadcast performance counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- req  input  NUM_REQ  level request per unit; held until the unit sees its own tag on cdb.
- req_payload  input  NUM_REQ*PAYLOAD_W  concatenated payloads; unit i occupies bits [i*PAYLOAD_W +: PAYLOAD_W].
- hold  input  1  when high, no grant is made this edge (debug single-step / memory-stall freeze).
- cdb  output  PAYLOAD_W+1  registered bus {valid (MSB), payload}; valid is the CDB_ON bit.
- grant  output  NUM_REQ  registered one-hot of the unit currently on cdb; all-zero when cdb valid is 0.
- bcast_count  output  CNT_W  number of valid broadcasts since reset; saturating.

Behaviour:
- Reset (async, asserted): cdb=0, grant=0, round-robin pointer ptr=0, bcast_count=0. Reset asserted mid-broadcast drops the bus immediately.
- Eligibility is evaluated at each rising clk: eligible = req & ~grant. grant is the current registered value, i.e. the winner now on the bus. This gives a one-cycle blackout for the previous winner.
- Selection: the first eligible index scanning ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1 (mod NUM_REQ).
- Winner w exists and hold=0:
  - cdb <= {1'b1, req_payload[w]}; the payload is sampled on that same edge.
  - grant <= onehot(w).
  - ptr <= (w+1) mod NUM_REQ.
  - bcast_count += 1, holding at all-ones once saturated.
- No eligible requester, or hold=1: cdb <= 0 (valid and payload all zero), grant <= 0, ptr unchanged, counter unchanged.
- Because hold clears grant, the blackout does not extend across a hold cycle; the previous winner is eligible again on the edge after hold.
- Latency: a request high at edge t with no competition appears on cdb from t until edge t+1 (one cycle).
- Each valid broadcast lasts exactly one cycle. Consumers (register status, RS lines, units) sample cdb on the falling edge.
- A requester granted at edge t is ineligible at t+1. If its req is still high at t+2, it is treated as a new result and may win.
- A requester dropping req before it wins loses nothing; no state is held per requester.
- Unselected payload bits are don't-care; X on a non-requesting slot must not propagate to cdb.
- NUM_REQ=1: a continuously asserted request is granted on alternate cycles only (blackout).
- ptr always lies in 0..NUM_REQ-1. Wrap from NUM_REQ-1 to 0 is required and must be covered.
- All outputs come straight from flops; there is no combinational path from req or req_payload to cdb.

Test Plan:
- Reset then req=5'b00001, payload0=38'h0A_DEADBEEF held at 1 from edge 1 → cdb=39'h4A_DEADBEEF, grant=00001 in the cycle after edge 1. Edge 2: cdb=0 (blackout). Edge 3: rebroadcast. bcast_count=2 after edge 3.
- req=5'b11111 held for 10 edges from ptr=0 → grant sequence 00001, 00010, 00100, 01000, 10000, 00001, …; ptr wraps 4→0. No unit is granted on two consecutive edges. bcast_count=10.
- req=5'b10001 held, ptr=2 → grant 10000 then 00001 then 10000; index 4 wins before index 0 (wrap scan).
- hold=1 for 3 edges with req=5'b00110 → cdb valid=0, grant=0, ptr and counter frozen. hold=0 → grant 00010 first (ptr was 1).
- rst asserted asynchronously between edges while cdb valid=1 → cdb, grant and bcast_count are 0 immediately, before the next clk edge. After release, first grant goes to the lowest requesting index.
- Preload bcast_count to all-ones (force, or CNT_W=4 build with 16 grants), then one more grant → count stays at all-ones; cdb still broadcasts normally.
